frame_bin_accumulator: RTL and testbench
========================================

Name: frame_bin_accumulator

Overview:
Multi-bin, multi-frame accumulator for STFT power-spectrum averaging. Consumes a stream of per-bin magnitudes (NBIN bins per frame) and sums each bin over NFRAME consecutive frames in an internal per-bin register bank. On the last frame of each set it emits the per-bin totals and then restarts the next set with no idle cycles. It sits between the STFT magnitude stage and the classifier feature buffer, and is the parametrised successor of the single-value accumulator.

Parameters:
IL, 10, input sample width (unsigned)
OL, 14, accumulator/output width; must satisfy OL >= IL
NBIN, 16, bins per frame; must be >= 2
NFRAME, 9, frames summed per output set; must be >= 1
SAT, 1, 1 = saturate at 2^OL-1 on overflow, 0 = wrap modulo 2^OL

Ports:
iCLK  input  1  clock, rising edge
iRST  input  1  asynchronous active-high reset
iCLR  input  1  synchronous restart of the bin and frame counters, and clear of oOVF
iEN  input  1  iDATA valid this cycle; one sample per bin, bins in order 0..NBIN-1
iDATA  input  IL  bin magnitude
oEN  output  1  oDATA/oBIN valid (single-cycle strobe)
oDATA  output  OL  accumulated sum for bin oBIN
oBIN  output  clog2(NBIN)  bin index of oDATA
oLAST  output  1  high with oEN when oBIN == NBIN-1
oBUSY  output  1  a set is partially accumulated (bin_cnt != 0 or frm_cnt != 0)
oOVF  output  1  sticky: some sum saturated or wrapped since reset or iCLR

Behaviour:
- One clock, iCLK. Reset is asynchronous and active-high on iRST.
- On reset, oEN, oDATA, oBIN, oLAST, oOVF and oBUSY are all 0, and bin_cnt = frm_cnt = 0.
- The bank mem[0..NBIN-1] (OL bits each) is not reset. Frame 0 overwrites it, so no stale data can reach the output.
- Per accepted sample (iEN = 1), with b = bin_cnt and f = frm_cnt:
  - sum = (f == 0) ? zero-extend(iDATA) : mem[b] + iDATA, computed at OL+1 bits.
  - If the carry bit is set: SAT = 1 gives sum = 2^OL-1; SAT = 0 keeps the low OL bits. Either way oOVF <= 1.
  - mem[b] <= sum.
  - If f == NFRAME-1: next cycle oEN = 1, oDATA = sum, oBIN = b, oLAST = (b == NBIN-1). Latency is 1 cycle from the accepted sample.
  - bin_cnt advances and wraps at NBIN-1. On that wrap, frm_cnt advances and wraps at NFRAME-1.
- NFRAME = 1: every sample is passed through zero-extended, with oEN asserted for each.
- iEN = 0: counters, memory and oOVF hold; oEN <= 0.
- iCLR = 1 has priority over counter state:
  - bin_cnt and frm_cnt restart at 0, oOVF <= 0, oEN <= 0.
  - If iEN is high in the same cycle, the sample is accepted as bin 0 of frame 0 and the counters end at bin_cnt = 1, frm_cnt = 0.
  - If that sample also completes a set (NFRAME = 1), oEN follows the accept rule, not the clear.
  - An overflow caused by that same sample sets oOVF; set wins over clear.
- Asserting iRST mid-set abandons the partial set. No oEN is produced for it. The next sample is bin 0 of frame 0.
- oBUSY is combinational from the counters.
- No back-pressure. The downstream block must accept one oEN per cycle.

Decomposition:
- Shared package/include: a clog2 function, bin/frame counter width localparams, and the SAT mode constants.
- One sub-module, acc_sat_add: (OL-bit a, IL-bit b, load-first flag, SAT) -> OL-bit sum plus overflow flag. Combinational, instantiated once.
- The counters, register bank and output registers stay in frame_bin_accumulator.

Test Plan:
- NBIN=4, NFRAME=3, SAT=1. Feed 12 samples, all value 5, continuous iEN. Expect 4 oEN strobes, 1 cycle after samples 9..12, each oDATA=15, oBIN=0..3, oLAST only on bin 3, oOVF=0. oBUSY=0 afterwards.
- Same config, iEN gapped with random idle cycles. Expect identical outputs and no oEN during gaps.
- IL=10, OL=11, NFRAME=3, SAT=1. Feed bin 0 with 1023 three times. Expect oDATA=2047 and oOVF=1. Repeat with SAT=0: expect oDATA=(3069 mod 2048)=1021 and oOVF=1.
- Assert iCLR mid-set (after 6 samples) together with iEN and value 7. Expect no oEN from the old set, oOVF=0, and bin 0 of the new set's output to include 7.
- Pulse iRST after 5 samples. Expect all outputs 0 immediately (async), then a full fresh set accumulates correctly.
- NFRAME=1. Feed values 1,2,3,4. Expect pass-through oDATA=1,2,3,4 with oBIN=0..3, oEN each cycle after input, oLAST on the 4th.

Source files
------------

// File: rtl/frame_bin_accumulator_pkg.sv
// Shared constants and helpers for the frame/bin accumulator.
package frame_bin_accumulator_pkg;

  // Saturation mode selectors for the SAT parameter
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  // Default geometry, kept for blocks that size buffers off this unit
  localparam int NBIN_DEF   = 16;
  localparam int NFRAME_DEF = 9;

  // Ceil(log2(n)), never below 1 so a counter always has at least one bit
  function automatic int fba_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int BIN_W_DEF = fba_clog2(NBIN_DEF);
  localparam int FRM_W_DEF = fba_clog2(NFRAME_DEF);

endpackage

// File: rtl/frame_bin_accumulator_if.sv
// Sample stream in, per-bin totals out. Master drives samples, slave is the accumulator.
interface frame_bin_accumulator_if
  import frame_bin_accumulator_pkg::*;
#(
  parameter int IL   = 10,
  parameter int OL   = 14,
  parameter int NBIN = NBIN_DEF
);
  localparam int BW = fba_clog2(NBIN);

  logic          iCLR;
  logic          iEN;
  logic [IL-1:0] iDATA;
  logic          oEN;
  logic [OL-1:0] oDATA;
  logic [BW-1:0] oBIN;
  logic          oLAST;
  logic          oBUSY;
  logic          oOVF;

  modport master (
    output iCLR, iEN, iDATA,
    input  oEN, oDATA, oBIN, oLAST, oBUSY, oOVF
  );

  modport slave (
    input  iCLR, iEN, iDATA,
    output oEN, oDATA, oBIN, oLAST, oBUSY, oOVF
  );
endinterface

// File: rtl/frame_bin_accumulator_acc_sat_add.sv
// Combinational add of one sample into a bin total, with clamp-or-wrap on carry.
module acc_sat_add #(
  parameter int IL = 10,
  parameter int OL = 14
) (
  input  logic [OL-1:0] a,
  input  logic [IL-1:0] b,
  input  logic          load,
  input  logic          sat,
  output logic [OL-1:0] sum,
  output logic          ovf
);
  logic [OL:0] full;

  // Load ignores the stored total so the first frame of a set starts clean
  always_comb begin
    full = {1'b0, (load ? '0 : a)} + (OL+1)'(b);
    ovf  = full[OL];
    sum  = (ovf && sat) ? '1 : full[OL-1:0];
  end
endmodule

// File: rtl/frame_bin_accumulator.sv
// Sums each of NBIN bins over NFRAME frames and streams the totals on the last frame.
module frame_bin_accumulator
  import frame_bin_accumulator_pkg::*;
#(
  parameter int IL     = 10,
  parameter int OL     = 14,
  parameter int NBIN   = NBIN_DEF,
  parameter int NFRAME = NFRAME_DEF,
  parameter int SAT    = SAT_CLAMP
) (
  input logic                   iCLK,
  input logic                   iRST,
  frame_bin_accumulator_if.slave bus
);
  localparam int BW = fba_clog2(NBIN);
  localparam int FW = fba_clog2(NFRAME);

  logic [BW-1:0] binCnt, binCur;
  logic [FW-1:0] frmCnt, frmCur;
  logic          binLast, frmLast, frmFirst;
  logic [OL-1:0] mem [NBIN];
  logic [OL-1:0] sum;
  logic          sumOvf;
  logic          enQ, lastQ, ovfQ;
  logic [OL-1:0] dataQ;
  logic [BW-1:0] binQ;

  // A clear in the same cycle as a sample makes that sample bin 0 of frame 0
  assign binCur   = bus.iCLR ? '0 : binCnt;
  assign frmCur   = bus.iCLR ? '0 : frmCnt;
  assign binLast  = (binCur == BW'(NBIN - 1));
  assign frmLast  = (frmCur == FW'(NFRAME - 1));
  assign frmFirst = (frmCur == '0);

  acc_sat_add #(.IL(IL), .OL(OL)) u_add (
    .a    (mem[binCur]),
    .b    (bus.iDATA),
    .load (frmFirst),
    .sat  (SAT == SAT_CLAMP),
    .sum  (sum),
    .ovf  (sumOvf)
  );

  // Bin bank is not reset: frame 0 always overwrites before anything is read out
  always_ff @(posedge iCLK) begin
    if (bus.iEN) mem[binCur] <= sum;
  end

  // Counters, sticky overflow and the one-cycle output strobe
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      binCnt <= '0;
      frmCnt <= '0;
      ovfQ   <= 1'b0;
      enQ    <= 1'b0;
      dataQ  <= '0;
      binQ   <= '0;
      lastQ  <= 1'b0;
    end else begin
      enQ <= 1'b0;
      if (bus.iCLR) begin
        binCnt <= '0;
        frmCnt <= '0;
        ovfQ   <= 1'b0;
      end
      if (bus.iEN) begin
        binCnt <= binLast ? '0 : binCur + BW'(1);
        if (binLast) frmCnt <= frmLast ? '0 : frmCur + FW'(1);
        else         frmCnt <= frmCur;
        // Overflow of the accepted sample wins over a simultaneous clear
        if (sumOvf) ovfQ <= 1'b1;
        if (frmLast) begin
          enQ   <= 1'b1;
          dataQ <= sum;
          binQ  <= binCur;
          lastQ <= binLast;
        end
      end
    end
  end

  assign bus.oEN   = enQ;
  assign bus.oDATA = dataQ;
  assign bus.oBIN  = binQ;
  assign bus.oLAST = lastQ;
  assign bus.oOVF  = ovfQ;
  assign bus.oBUSY = (binCnt != '0) || (frmCnt != '0);
endmodule

// File: tb/tb_frame_bin_accumulator.sv
// Four accumulator configurations driven by one shared stream, each checked
// against a per-set running-total model.
module tb_frame_bin_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr, en;
  logic [9:0] data;

  always #5 clk = ~clk;

  // A: default-ish, B: narrow clamp, C: narrow wrap, D: pass-through
  frame_bin_accumulator_if #(.IL(10), .OL(14), .NBIN(4)) ifA ();
  frame_bin_accumulator_if #(.IL(10), .OL(11), .NBIN(4)) ifB ();
  frame_bin_accumulator_if #(.IL(10), .OL(11), .NBIN(4)) ifC ();
  frame_bin_accumulator_if #(.IL(10), .OL(14), .NBIN(4)) ifD ();

  frame_bin_accumulator #(.IL(10), .OL(14), .NBIN(4), .NFRAME(3), .SAT(1))
    dutA (.iCLK(clk), .iRST(rst), .bus(ifA));
  frame_bin_accumulator #(.IL(10), .OL(11), .NBIN(4), .NFRAME(3), .SAT(1))
    dutB (.iCLK(clk), .iRST(rst), .bus(ifB));
  frame_bin_accumulator #(.IL(10), .OL(11), .NBIN(4), .NFRAME(3), .SAT(0))
    dutC (.iCLK(clk), .iRST(rst), .bus(ifC));
  frame_bin_accumulator #(.IL(10), .OL(14), .NBIN(4), .NFRAME(1), .SAT(1))
    dutD (.iCLK(clk), .iRST(rst), .bus(ifD));

  assign ifA.iCLR = clr; assign ifA.iEN = en; assign ifA.iDATA = data;
  assign ifB.iCLR = clr; assign ifB.iEN = en; assign ifB.iDATA = data;
  assign ifC.iCLR = clr; assign ifC.iEN = en; assign ifC.iDATA = data;
  assign ifD.iCLR = clr; assign ifD.iEN = en; assign ifD.iDATA = data;

  logic [3:0]       oE, oBs, oO, oL;
  logic [3:0][13:0] oD;
  logic [3:0][1:0]  oBn;
  assign oE  = {ifD.oEN,   ifC.oEN,   ifB.oEN,   ifA.oEN};
  assign oBs = {ifD.oBUSY, ifC.oBUSY, ifB.oBUSY, ifA.oBUSY};
  assign oO  = {ifD.oOVF,  ifC.oOVF,  ifB.oOVF,  ifA.oOVF};
  assign oL  = {ifD.oLAST, ifC.oLAST, ifB.oLAST, ifA.oLAST};
  assign oD[0] = ifA.oDATA;
  assign oD[1] = {3'b0, ifB.oDATA};
  assign oD[2] = {3'b0, ifC.oDATA};
  assign oD[3] = ifD.oDATA;
  assign oBn = {ifD.oBIN, ifC.oBIN, ifB.oBIN, ifA.oBIN};

  // Reference model: sample count within the set plus true per-bin totals
  int     mOL [4] = '{14, 11, 11, 14};
  int     mNF [4] = '{3, 3, 3, 1};
  int     mSAT[4] = '{1, 1, 0, 1};
  int     cnt [4];
  longint tot [4][4];
  bit     mOvf[4];
  bit     eEn [4];
  longint eData[4];
  int     eBin[4];
  bit     eLast[4];

  int compared = 0;
  int mism     = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s dut%0d t=%0t observed=%0d expected=%0d", tag, k, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0; mOvf[k] = 0; eEn[k] = 0;
      eData[k] = 0; eBin[k] = 0; eLast[k] = 0;
    end
  endtask

  task automatic model(input bit c, input bit e, input int d);
    for (int k = 0; k < 4; k++) begin
      longint mx;
      int b, f;
      mx = (longint'(1) << mOL[k]) - 1;
      eEn[k] = 0;
      if (c) begin cnt[k] = 0; mOvf[k] = 0; end
      if (e) begin
        b = cnt[k] % 4;
        f = cnt[k] / 4;
        tot[k][b] = (f == 0) ? longint'(d) : tot[k][b] + d;
        if (tot[k][b] > mx) mOvf[k] = 1;
        if (f == mNF[k] - 1) begin
          eEn[k]   = 1;
          eData[k] = (mSAT[k] == 1) ? ((tot[k][b] > mx) ? mx : tot[k][b]) : (tot[k][b] % (mx + 1));
          eBin[k]  = b;
          eLast[k] = (b == 3);
        end
        cnt[k] = (cnt[k] + 1) % (4 * mNF[k]);
      end
    end
  endtask

  task automatic check_all(input bit full);
    for (int k = 0; k < 4; k++) begin
      chk("oEN",   k, 32'(oE[k]),  32'(eEn[k]));
      chk("oBUSY", k, 32'(oBs[k]), 32'(cnt[k] != 0));
      chk("oOVF",  k, 32'(oO[k]),  32'(mOvf[k]));
      if (eEn[k] || full) begin
        chk("oDATA", k, 32'(oD[k]),  32'(eData[k]));
        chk("oBIN",  k, 32'(oBn[k]), 32'(eBin[k]));
        chk("oLAST", k, 32'(oL[k]),  32'(eLast[k]));
      end
    end
  endtask

  task automatic cyc(input bit c, input bit e, input int d);
    clr = c; en = e; data = 10'(d);
    @(posedge clk);
    model(c, e, d);
    #1;
    check_all(1'b0);
  endtask

  // Called at posedge+1; reset is released well before the next edge
  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    model_reset();
    check_all(1'b1);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    clr = 1'b0; en = 1'b0; data = '0;
    #1 rst = 1'b1;
    #2;
    model_reset();
    check_all(1'b1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Full set of constant 5s, continuous
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 5);
    cyc(1'b0, 1'b0, 0);

    // Same set with random idle gaps
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b1, 5);
    end
    cyc(1'b0, 1'b0, 0);

    // Max-value set: overflows the 11-bit configurations
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1023);
    cyc(1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 0);

    // Clear mid-set, with a sample of 7 accepted as bin 0 of the new set
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, $urandom_range(0, 200));
    cyc(1'b1, 1'b1, 7);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, $urandom_range(0, 200));
    cyc(1'b0, 1'b0, 0);

    // Async reset mid-set, then a fresh full set
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, $urandom_range(0, 1023));
    pulse_rst();
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, $urandom_range(0, 1023));
    cyc(1'b0, 1'b0, 0);

    // Pass-through pattern on the single-frame configuration
    cyc(1'b1, 1'b0, 0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, i);
    cyc(1'b0, 1'b0, 0);

    // Random traffic with occasional clears
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70), $urandom_range(0, 1023));
    cyc(1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
